// File: rtl/sa_ram_pkg.sv
// Shared constants and helpers for the single-port-read / single-port-write RAM.
// Holds address sizing, collision-counter width and lane-width arithmetic.
package sa_ram_pkg;

    localparam int COLL_CNT_W = 8;

    // Address bits needed for a given depth, never less than one
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < v) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int lane_width(input int w, input int l);
        return w / l;
    endfunction

endpackage

// File: rtl/sa_ram_rd_pipe.sv
// Read stage: address capture, pending-read tracking, collision bypass,
// output register, valid strobe and saturating collision counter.
module sa_ram_rd_pipe
    import sa_ram_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LANES  = 2,
    parameter int BYPASS = 1,
    parameter int AW     = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [AW-1:0]         i_ra,
    input  logic                  i_re,
    input  logic                  i_ore,
    input  logic [AW-1:0]         i_wa,
    input  logic                  i_we,
    input  logic                  i_wa_ok,
    input  logic [LANES-1:0]      i_wmask,
    input  logic [WIDTH-1:0]      i_di,
    input  logic [WIDTH-1:0]      i_rd_word,
    output logic [AW-1:0]         o_ra_d,
    output logic [WIDTH-1:0]      o_dout,
    output logic                  o_dout_vld,
    output logic [COLL_CNT_W-1:0] o_coll_cnt
);

    localparam int LW = lane_width(WIDTH, LANES);

    logic [AW-1:0]         r_ra_d;
    logic                  r_rd_pend;
    logic [WIDTH-1:0]      r_dout;
    logic                  r_dout_vld;
    logic [COLL_CNT_W-1:0] r_coll_cnt;
    logic                  w_coll;
    logic [WIDTH-1:0]      w_next;

    assign w_coll = i_we & i_ore & i_wa_ok & (i_wa == r_ra_d);

    // Merge in-flight write lanes over the array word when bypass is enabled
    always_comb begin
        w_next = i_rd_word;
        if ((BYPASS != 0) && w_coll) begin
            for (int i = 0; i < LANES; i++) begin
                if (i_wmask[i]) w_next[i*LW +: LW] = i_di[i*LW +: LW];
            end
        end
    end

    // Read-side state; re wins over ore when clearing the pending flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ra_d     <= '0;
            r_rd_pend  <= 1'b0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_coll_cnt <= '0;
        end else begin
            if (i_re) r_ra_d <= i_ra;
            if (i_re) r_rd_pend <= 1'b1;
            else if (i_ore) r_rd_pend <= 1'b0;
            if (i_ore) r_dout <= w_next;
            r_dout_vld <= i_ore & r_rd_pend;
            if (w_coll && (r_coll_cnt != '1)) r_coll_cnt <= r_coll_cnt + 1'b1;
        end
    end

    assign o_ra_d     = r_ra_d;
    assign o_dout     = r_dout;
    assign o_dout_vld = r_dout_vld;
    assign o_coll_cnt = r_coll_cnt;

endmodule

// File: rtl/sa_ram_rwsp_param.sv
// Parameterised RAM with lane-masked writes and a registered read pipe.
// Array contents survive reset; only the read stage is cleared.
module sa_ram_rwsp_param
    import sa_ram_pkg::*;
#(
    parameter int       DEPTH  = 256,
    parameter int       WIDTH  = 16,
    parameter int       LANES  = 2,
    parameter int       BYPASS = 1,
    parameter bit       FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b0,
    localparam int      AW     = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [AW-1:0]         ra,
    input  logic                  re,
    input  logic                  ore,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_vld,
    input  logic [AW-1:0]         wa,
    input  logic                  we,
    input  logic [LANES-1:0]      wmask,
    input  logic [WIDTH-1:0]      di,
    output logic [COLL_CNT_W-1:0] coll_cnt,
    input  logic [31:0]           pwrbus_ram_pd
);

    localparam int        LW      = lane_width(WIDTH, LANES);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    generate
        if (WIDTH % LANES != 0) begin : g_bad_lanes
            $error("sa_ram_rwsp_param: WIDTH must be a multiple of LANES");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    w_ra_d;
    logic             w_wa_ok;
    logic             w_rd_ok;
    logic [WIDTH-1:0] w_rd_word;
    logic             w_unused;

    assign w_wa_ok   = {1'b0, wa} < DEPTH_C;
    assign w_rd_ok   = {1'b0, w_ra_d} < DEPTH_C;
    assign w_rd_word = w_rd_ok ? r_mem[w_ra_d] : '0;
    assign w_unused  = ^{1'b0, pwrbus_ram_pd,
                         FORCE_CONTENTION_ASSERTION_RESET_ACTIVE};

    // Lane-masked array write; out-of-range addresses are dropped
    always_ff @(posedge clk) begin
        if (we && w_wa_ok) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask[i]) r_mem[wa][i*LW +: LW] <= di[i*LW +: LW];
            end
        end
    end

    sa_ram_rd_pipe #(
        .WIDTH  (WIDTH),
        .LANES  (LANES),
        .BYPASS (BYPASS),
        .AW     (AW)
    ) u_rd_pipe (
        .clk        (clk),
        .rstn       (rstn),
        .i_ra       (ra),
        .i_re       (re),
        .i_ore      (ore),
        .i_wa       (wa),
        .i_we       (we),
        .i_wa_ok    (w_wa_ok),
        .i_wmask    (wmask),
        .i_di       (di),
        .i_rd_word  (w_rd_word),
        .o_ra_d     (w_ra_d),
        .o_dout     (dout),
        .o_dout_vld (dout_vld),
        .o_coll_cnt (coll_cnt)
    );

endmodule

// File: doc/sa_ram_rwsp_param.md
SA_RAM_RWSP_PARAM -- requirements
Module: sa_ram_rwsp_param

Interface
- REQ-001 SHALL have parameter DEPTH, default 256: number of words.
- REQ-002 SHALL have parameter WIDTH, default 16: data bits per word.
- REQ-003 SHALL have parameter LANES, default 2: write-mask lanes; WIDTH % LANES == 0; lane width LW = WIDTH/LANES.
- REQ-004 SHALL have parameter BYPASS, default 1: 1 forwards write data on a read/write collision, 0 returns old array data.
- REQ-005 SHALL have parameter FORCE_CONTENTION_ASSERTION_RESET_ACTIVE, default 1'b0: kept for compatibility, no functional effect.
- REQ-006 SHALL use address width AW = clog2(DEPTH), minimum 1.
- REQ-007 clk  input  1  single clock; all state updates on its rising edge.
- REQ-008 rstn  input  1  asynchronous, active-low reset.
- REQ-009 ra  input  AW  read address.
- REQ-010 re  input  1  read address capture enable.
- REQ-011 ore  input  1  output register enable.
- REQ-012 dout  output  WIDTH  registered read data.
- REQ-013 dout_vld  output  1  dout updated this cycle with a pending read.
- REQ-014 wa  input  AW  write address.
- REQ-015 we  input  1  write enable.
- REQ-016 wmask  input  LANES  per-lane write enable; bit i covers di[i*LW +: LW].
- REQ-017 di  input  WIDTH  write data.
- REQ-018 coll_cnt  output  8  saturating read/write collision count.
- REQ-019 pwrbus_ram_pd  input  32  power-down bus; ignored functionally.

Function
- REQ-020 On a clk edge with we=1 and wa<DEPTH, each lane i with wmask[i]=1 SHALL be written from di; unmasked lanes SHALL keep their value.
- REQ-021 A write with wa>=DEPTH SHALL be dropped.
- REQ-022 re=1 SHALL capture ra into internal ra_d; re=0 SHALL hold ra_d.
- REQ-023 ore=1 SHALL load dout with the pre-edge array word at ra_d; ore=0 SHALL hold dout; nominal latency re->dout is 2 edges.
- REQ-024 ra_d>=DEPTH SHALL load dout with zero.
- REQ-025 Collision = we & ore & (wa==ra_d) & (wa<DEPTH) on the same edge.
- REQ-026 On a collision with BYPASS=1, masked lanes of dout SHALL take di and unmasked lanes the array value; with BYPASS=0 the whole of dout SHALL take the pre-write array value.
- REQ-027 Each collision SHALL increment coll_cnt by 1, saturating at 255.
- REQ-028 Internal flag rd_pend SHALL be set by re=1 and cleared by ore=1 with re=0; re and ore together SHALL leave it set.
- REQ-029 dout_vld SHALL be registered as ore & rd_pend, one cycle wide per ore.
- REQ-030 ore without a pending read SHALL still load dout, with dout_vld=0.
- REQ-031 A simultaneous re and we on the same address SHALL capture only the address; the data returned is decided at the ore edge (REQ-023/026).

Reset
- REQ-032 rstn=0 SHALL asynchronously clear ra_d, dout, dout_vld, rd_pend and coll_cnt to 0.
- REQ-033 Reset SHALL NOT clear array contents; a read of an unwritten word returns undefined data.
- REQ-034 Reset asserted mid-read SHALL discard the pending read; no dout_vld follows release.
- REQ-035 Deassertion SHALL be synchronised externally; the first edge after release operates normally.

Structure
- REQ-036 Shared package sa_ram_pkg SHALL hold clog2, the 8-bit collision-counter width constant and the lane-width helper.
- REQ-037 The read stage (ra_d, rd_pend, bypass merge, dout, dout_vld) SHALL be one sub-module, sa_ram_rd_pipe; the array and write masking stay in the top.
- REQ-038 A parameter check SHALL flag WIDTH % LANES != 0 at elaboration.

Verification
- REQ-039 Reset, write 0xBEEF to addr 5 with wmask=11, then re on ra=5, then ore -> dout=0xBEEF with dout_vld=1 two edges after re.
- REQ-040 Addr 5=0xBEEF, write di=0x1234 with wmask=01 -> reads back 0xBE34.
- REQ-041 BYPASS=1: ra_d=7 holds 0xAAAA; ore with we, wa=7, di=0x5555, wmask=10 -> dout=0x55AA, coll_cnt=1. BYPASS=0: same stimulus -> dout=0xAAAA.
- REQ-042 300 collisions -> coll_cnt=255; rstn pulse -> coll_cnt=0, dout=0, memory retained.
- REQ-043 DEPTH=200: write addr 210 then read addr 210 -> dout=0; addr 199 reads correctly.
- REQ-044 ore without a preceding re -> dout updates, dout_vld=0; rstn pulse between re and ore -> no dout_vld.
